// File: rtl/dcache_controller_if.sv
// CPU-side load/store bus of the data cache.
//   read, write   : request strobes, held by the CPU until busywait is low
//   address       : byte address {tag, index, offset}
//   writedata     : store byte
//   readdata      : load byte, valid in the cycle busywait is low on a read
//   busywait      : stall; the request completes at the posedge where it is low
// Handshake: a request (read ^ write) is accepted and completes at the first
// posedge where busywait is low; the CPU keeps read/write/address/writedata
// stable until then. read && write together is not a request.
interface dcache_controller_if;
    logic       read;
    logic       write;
    logic [7:0] address;
    logic [7:0] writedata;
    logic [7:0] readdata;
    logic       busywait;

    modport master (output read, write, address, writedata, input readdata, busywait);
    modport slave  (input read, write, address, writedata, output readdata, busywait);
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate byte cache in front of a 64-block
// (256 x 8) memory. Misses write back a dirty victim, then refill the block.
// Ports:
//   clock, reset   : clock and synchronous active-low reset
//   cpu            : CPU load/store bus (slave side)
//   mem_read/write : block read / write-back request to memory
//   mem_address    : block address {tag, index}
//   mem_writedata  : block being written back, byte0 = [7:0]
//   mem_readdata   : refill block, byte0 = [7:0]
//   mem_busywait   : memory busy; a transfer ends at a posedge where it is low
//   hit_count      : saturating count of hits served without a miss
//   miss_count     : saturating count of misses taken
//   o_state        : controller state (0 IDLE, 1 WRITEBACK, 2 FETCH)
module dcache_controller #(
    parameter int INDEX_BITS = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    dcache_controller_if.slave   cpu,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [5:0]           mem_address,
    output logic [31:0]          mem_writedata,
    input  logic [31:0]          mem_readdata,
    input  logic                 mem_busywait,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [1:0]           o_state
);
    localparam int TAG_BITS = 6 - INDEX_BITS;
    localparam int NBLK     = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_FETCH     = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [NBLK-1:0]       r_valid;
    logic [NBLK-1:0]       r_dirty;
    logic [TAG_BITS-1:0]   r_tag  [NBLK];
    logic [31:0]           r_data [NBLK];
    logic                  r_refilled;
    logic [CNT_WIDTH-1:0]  r_hit_count;
    logic [CNT_WIDTH-1:0]  r_miss_count;

    logic [TAG_BITS-1:0]   w_tag;
    logic [INDEX_BITS-1:0] w_idx;
    logic [1:0]            w_off;
    logic [31:0]           w_block;
    logic [7:0]            w_byte;
    logic                  w_req;
    logic                  w_hit;
    logic                  w_busywait;
    logic [7:0]            w_readdata;
    logic                  w_do_write;
    logic                  w_count_hit;
    logic                  w_count_miss;
    logic                  w_refill;

    assign w_tag   = cpu.address[7 -: TAG_BITS];
    assign w_idx   = cpu.address[2 +: INDEX_BITS];
    assign w_off   = cpu.address[1:0];
    assign w_block = r_data[w_idx];
    assign w_byte  = w_block[{w_off, 3'b000} +: 8];
    assign w_req   = cpu.read ^ cpu.write;
    assign w_hit   = w_req && r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    always_comb begin
        w_next_state  = r_state;
        w_busywait    = 1'b0;
        w_readdata    = 8'h00;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = 6'd0;
        mem_writedata = 32'd0;
        w_do_write    = 1'b0;
        w_count_hit   = 1'b0;
        w_count_miss  = 1'b0;
        w_refill      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_hit) begin
                    // w_hit implies exactly one of read/write
                    w_readdata = cpu.read ? w_byte : 8'h00;
                    w_do_write = cpu.write;
                    // the access right after a refill already counted as a miss
                    w_count_hit = !r_refilled;
                end else if (w_req) begin
                    w_busywait   = 1'b1;
                    w_count_miss = 1'b1;
                    w_next_state = (r_valid[w_idx] && r_dirty[w_idx]) ? S_WRITEBACK : S_FETCH;
                end
            end
            S_WRITEBACK: begin
                w_busywait    = 1'b1;
                mem_write     = 1'b1;
                mem_address   = {r_tag[w_idx], w_idx};
                mem_writedata = w_block;
                if (!mem_busywait) w_next_state = S_FETCH;
            end
            S_FETCH: begin
                w_busywait  = 1'b1;
                mem_read    = 1'b1;
                mem_address = {w_tag, w_idx};
                if (!mem_busywait) begin
                    w_next_state = S_IDLE;
                    w_refill     = 1'b1;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_valid      <= '0;
            r_dirty      <= '0;
            r_refilled   <= 1'b0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            r_state    <= w_next_state;
            r_refilled <= w_refill;
            if (w_refill) begin
                r_valid[w_idx] <= 1'b1;
                r_dirty[w_idx] <= 1'b0;
            end else if (w_do_write) begin
                r_dirty[w_idx] <= 1'b1;
            end
            if (w_count_hit && (r_hit_count != '1))
                r_hit_count <= r_hit_count + 1'b1;
            if (w_count_miss && (r_miss_count != '1))
                r_miss_count <= r_miss_count + 1'b1;
        end
    end

    // Tag and data storage need no reset: valid bits qualify them.
    always_ff @(posedge clock) begin
        if (reset) begin
            if (w_refill) begin
                r_data[w_idx] <= mem_readdata;
                r_tag[w_idx]  <= w_tag;
            end else if (w_do_write) begin
                r_data[w_idx][{w_off, 3'b000} +: 8] <= cpu.writedata;
            end
        end
    end

    assign cpu.busywait = w_busywait;
    assign cpu.readdata = w_readdata;
    assign hit_count    = r_hit_count;
    assign miss_count   = r_miss_count;
    assign o_state      = r_state;
endmodule

// File: tb/tb_dcache_controller.sv
module tb_dcache_controller;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          mem_read, mem_write;
  logic [5:0]    mem_address;
  logic [31:0]   mem_writedata;
  logic [31:0]   mem_readdata;
  logic          mem_busywait;
  logic [CW-1:0] hit_count, miss_count;
  logic [1:0]    o_state;

  dcache_controller_if cpu_if ();

  dcache_controller #(.INDEX_BITS(3), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .cpu(cpu_if),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_busywait(mem_busywait), .hit_count(hit_count), .miss_count(miss_count),
    .o_state(o_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // memory responder: busy for mem_lat cycles of each transfer, then grants
  logic [31:0] mem [64];
  int          mem_lat = 1;
  int          mem_cnt = 0;

  initial begin
    mem_busywait = 1'b0;
    mem_readdata = 32'd0;
    for (int b = 0; b < 64; b++)
      for (int k = 0; k < 4; k++) mem[b][8*k +: 8] = 8'(4*b + k) ^ 8'hC3;
    forever begin
      @(posedge clock); #2;
      if (mem_read || mem_write) begin
        if (mem_cnt < mem_lat) begin
          mem_busywait = 1'b1;
          mem_cnt++;
        end else begin
          mem_busywait = 1'b0;
          mem_cnt = 0;
          if (mem_write) mem[mem_address] = mem_writedata;
        end
      end else begin
        mem_busywait = 1'b0;
        mem_cnt = 0;
      end
      mem_readdata = mem[mem_address];
    end
  end

  // behavioural model: cache contents, backing memory, counters
  logic        m_valid [8];
  logic        m_dirty [8];
  logic [2:0]  m_tag   [8];
  logic [31:0] m_data  [8];
  logic [31:0] m_mem   [64];
  int          m_hits = 0;
  int          m_misses = 0;

  // scoreboard: {is_writeback, block address, writeback data}
  logic [38:0] exp_q[$];

  logic          cur_active = 1'b0;
  logic          cur_read = 1'b0;
  logic [7:0]    exp_rd = 8'h00;
  logic [CW-1:0] exp_hits = '0;
  logic [CW-1:0] exp_misses = '0;
  int            wb_seen = 0;
  int            rd_seen = 0;
  logic [5:0]    last_wb_addr = '0;
  logic [31:0]   last_wb_data = '0;
  logic [5:0]    last_rd_addr = '0;
  logic [7:0]    last_rdata = '0;

  function automatic logic [CW-1:0] sat(input int c);
    return (c >= (1 << CW) - 1) ? '1 : CW'(c);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_hits = 0;
    m_misses = 0;
    exp_q.delete();
  endtask

  // compare process
  initial begin
    logic [38:0] e;
    forever begin
      @(negedge clock);
      if (reset) begin
        chk("mem_exclusive", 64'(mem_read && mem_write), 64'd0);
        if ((mem_read || mem_write) && !mem_busywait) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL mem_unexpected: got rd=%0b wr=%0b addr=%0h required no transfer",
                     mem_read, mem_write, mem_address);
          end else begin
            e = exp_q.pop_front();
            chk("mem_kind", 64'(mem_write), 64'(e[38]));
            chk("mem_address", 64'(mem_address), 64'(e[37:32]));
            if (mem_write) begin
              chk("wb_data", 64'(mem_writedata), 64'(e[31:0]));
              wb_seen++;
              last_wb_addr = mem_address;
              last_wb_data = mem_writedata;
            end else begin
              rd_seen++;
              last_rd_addr = mem_address;
            end
          end
        end
        if (cur_active && !cpu_if.busywait) begin
          if (cur_read) begin
            chk("readdata", 64'(cpu_if.readdata), 64'(exp_rd));
            last_rdata = cpu_if.readdata;
          end
          chk("hit_count", 64'(hit_count), 64'(exp_hits));
          chk("miss_count", 64'(miss_count), 64'(exp_misses));
        end
        if (!cur_active) begin
          chk("idle_busywait", 64'(cpu_if.busywait), 64'd0);
          chk("idle_readdata", 64'(cpu_if.readdata), 64'd0);
          chk("idle_memreq", 64'({mem_read, mem_write}), 64'd0);
        end
      end
    end
  end

  // driver: one CPU access, starting and ending just after a posedge
  task automatic access(input logic rd, input logic wr, input logic [7:0] addr, input logic [7:0] wd);
    logic [2:0] tag, idx;
    int         off, lat, n;
    logic       hit, done;
    tag = addr[7:5];
    idx = addr[4:2];
    off = int'(addr[1:0]);
    lat = 1;
    if (rd ^ wr) begin
      hit = m_valid[idx] && (m_tag[idx] == tag);
      if (!hit) begin
        m_misses++;
        lat = 1 + (mem_lat + 1) + 1;
        if (m_valid[idx] && m_dirty[idx]) begin
          exp_q.push_back({1'b1, m_tag[idx], idx, m_data[idx]});
          m_mem[{m_tag[idx], idx}] = m_data[idx];
          lat += mem_lat + 1;
        end
        exp_q.push_back({1'b0, tag, idx, 32'd0});
        m_valid[idx] = 1'b1;
        m_dirty[idx] = 1'b0;
        m_tag[idx]   = tag;
        m_data[idx]  = m_mem[addr[7:2]];
      end
      exp_hits   = sat(m_hits);
      exp_misses = sat(m_misses);
      if (hit) m_hits++;
      exp_rd = m_data[idx][8*off +: 8];
      if (wr) begin
        m_data[idx][8*off +: 8] = wd;
        m_dirty[idx] = 1'b1;
      end
    end else begin
      exp_hits   = sat(m_hits);
      exp_misses = sat(m_misses);
      exp_rd     = 8'h00;
    end
    cur_read   = rd && !wr;
    cur_active = 1'b1;
    cpu_if.read      = rd;
    cpu_if.write     = wr;
    cpu_if.address   = addr;
    cpu_if.writedata = wd;
    n = 0;
    done = 1'b0;
    while (!done && n < 200) begin
      @(negedge clock);
      n++;
      if (!cpu_if.busywait) done = 1'b1;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL access_timeout: got busywait high for %0d cycles at addr %0h required completion", n, addr);
    end else begin
      chk("latency", 64'(n), 64'(lat));
      if (rd && wr) chk("dual_readdata", 64'(cpu_if.readdata), 64'd0);
    end
    @(posedge clock); #1;
    cpu_if.read  = 1'b0;
    cpu_if.write = 1'b0;
    cur_active   = 1'b0;
  endtask

  initial begin
    int ws, rs;
    logic [7:0] a;
    cpu_if.read = 1'b0;
    cpu_if.write = 1'b0;
    cpu_if.address = 8'h00;
    cpu_if.writedata = 8'h00;
    for (int b = 0; b < 64; b++)
      for (int k = 0; k < 4; k++) m_mem[b][8*k +: 8] = 8'(4*b + k) ^ 8'hC3;
    model_reset();

    // reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_state", 64'(o_state), 64'd0);
    chk("rst_hits", 64'(hit_count), 64'd0);
    chk("rst_misses", 64'(miss_count), 64'd0);
    chk("rst_memreq", 64'({mem_read, mem_write}), 64'd0);
    chk("rst_memaddr", 64'(mem_address), 64'd0);
    chk("rst_memwdata", 64'(mem_writedata), 64'd0);
    reset = 1'b1;
    @(posedge clock); #1;

    // 1: cold read miss
    mem_lat = 1;
    access(1'b1, 1'b0, 8'h00, 8'h00);
    chk("t1_fetch_addr", 64'(last_rd_addr), 64'd0);
    chk("t1_data", 64'(last_rdata), 64'hC3);
    chk("t1_misses", 64'(miss_count), 64'd1);
    chk("t1_hits", 64'(hit_count), 64'd0);

    // 2: write then read back, the read needs no memory
    access(1'b0, 1'b1, 8'h05, 8'hAB);
    rs = rd_seen;
    access(1'b1, 1'b0, 8'h05, 8'h00);
    chk("t2_data", 64'(last_rdata), 64'hAB);
    chk("t2_no_mem", 64'(rd_seen), 64'(rs));
    chk("t2_hits", 64'(hit_count), 64'd1);

    // 3: dirty conflict on index 1
    mem_lat = 2;
    access(1'b0, 1'b1, 8'h04, 8'h11);
    access(1'b1, 1'b0, 8'h24, 8'h00);
    chk("t3_wb_addr", 64'(last_wb_addr), 64'd1);
    chk("t3_wb_byte0", 64'(last_wb_data[7:0]), 64'h11);
    chk("t3_wb_byte1", 64'(last_wb_data[15:8]), 64'hAB);
    chk("t3_fetch_addr", 64'(last_rd_addr), 64'd9);
    chk("t3_data", 64'(last_rdata), 64'hE7);
    ws = wb_seen;
    access(1'b1, 1'b0, 8'h04, 8'h00);
    chk("t3_clean_after", 64'(wb_seen), 64'(ws));
    chk("t3_written_back", 64'(last_rdata), 64'h11);

    // 4: clean conflict on index 2
    mem_lat = 0;
    ws = wb_seen;
    access(1'b1, 1'b0, 8'h08, 8'h00);
    access(1'b1, 1'b0, 8'h28, 8'h00);
    chk("t4_no_wb", 64'(wb_seen), 64'(ws));
    chk("t4_fetch_addr", 64'(last_rd_addr), 64'd10);

    // 6: read and write together are ignored
    access(1'b1, 1'b1, 8'h00, 8'h55);
    access(1'b1, 1'b0, 8'h00, 8'h00);
    chk("t6_unchanged", 64'(last_rdata), 64'hC3);

    // mixed vectors across indices and latencies
    for (int i = 0; i < 16; i++) begin
      mem_lat = i % 3;
      a = 8'((i * 37) & 8'hFF);
      access(1'(i % 2), 1'((i + 1) % 2), a, 8'(i * 3 + 1));
    end

    // 5: reset during FETCH aborts the transfer
    mem_lat = 3;
    cur_active = 1'b1;
    cur_read = 1'b0;
    cpu_if.read = 1'b1;
    cpu_if.address = 8'h40;
    begin
      int n;
      n = 0;
      while (!mem_read && n < 20) begin
        @(negedge clock);
        n++;
      end
      chk("t5_fetch_started", 64'(mem_read), 64'd1);
    end
    @(posedge clock); #1;
    cpu_if.read = 1'b0;
    reset = 1'b0;
    @(posedge clock); #1;
    chk("t5_state", 64'(o_state), 64'd0);
    chk("t5_mem_read", 64'(mem_read), 64'd0);
    chk("t5_busywait", 64'(cpu_if.busywait), 64'd0);
    model_reset();
    cur_active = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    access(1'b1, 1'b0, 8'h40, 8'h00);
    chk("t5_missed_again", 64'(miss_count), 64'd1);

    // counter saturation
    for (int i = 0; i < 18; i++) access(1'b1, 1'b0, 8'(8'h40 + (i % 4)), 8'h00);
    chk("sat_hits", 64'(hit_count), 64'hF);
    mem_lat = 0;
    for (int i = 0; i < 16; i++) access(1'b1, 1'b0, (i % 2) ? 8'h20 : 8'h00, 8'h00);
    chk("sat_misses", 64'(miss_count), 64'hF);
    chk("sat_hits_held", 64'(hit_count), 64'hF);

    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL leftover_transfers: got %0d pending required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
